tile_layer_gen: RTL and testbench
=================================

# tile_layer_gen

Parametrised tilemap scanline generator, successor to the fixed FG/BG layer generators in the NinjaKun video path. It walks one scroll-latched tile row per 8 pixels, fetches tile attributes from VRAM and 4bpp pattern data from character ROM, and emits one pixel per VCLK with palette, priority and opacity. It supports both existing attribute layouts plus an extended layout with per-tile H/V flip. One instance sits in front of the colour mixer per playfield layer.

## Interface
Parameters:
- COLS_LOG2, 5, log2 of tilemap width in tiles
- ROWS_LOG2, 5, log2 of tilemap height in tiles
- HOFS, 2, horizontal pipeline/position offset added to PH
- VOFS, 32, vertical offset added to PV
- HLATCH, 256, PH value at which scroll registers are sampled (must lie in hblank)
- ATTR_MODE, 0, attribute decode: 0 = BG, 1 = FG, 2 = EXT (BG + flips)

Ports:
- VCLK  in  1  pixel clock; single clock domain
- RESET  in  1  synchronous, active-high reset
- PH  in  9  CRTC horizontal count
- PV  in  9  CRTC vertical count
- SCX  in  8  horizontal scroll
- SCY  in  8  vertical scroll
- LEN  in  1  layer enable; low forces OPQ=0, pipeline keeps running
- VAD  out  COLS_LOG2+ROWS_LOG2  VRAM tile address {row, col}
- VDT  in  16  VRAM tile word
- CAD  out  13  char ROM address {chr[9:0], row[2:0]}
- CDT  in  32  char ROM word, 8 pixels × 4 bit
- PIX  out  4  pixel colour index
- PAL  out  4  palette select
- PRIO  out  1  priority bit
- OPQ  out  1  LEN & (PIX != 0)

## Operation
- Scroll latch: at PH==HLATCH, SCXL<=SCX and SCYL<=SCY. Both are zero-extended to 9 bits. Mid-line writes to SCX/SCY do not take effect until the next HLATCH.
- POSH = PH + SCXL + HOFS, and POSV = PV + SCYL + VOFS, both mod 512. Col = POSH[COLS_LOG2+2:3], row = POSV[ROWS_LOG2+2:3]; the map wraps naturally. Phase = POSH[2:0].
- Attribute decode from VDT:
  - Mode 0: chr={VDT[15:14],VDT[7:0]}, pal=VDT[11:8], prio=0, flips 0.
  - Mode 1: chr={1'b0,VDT[13],VDT[7:0]}, pal=VDT[11:8], prio=VDT[12], flips 0.
  - Mode 2: as mode 0, with hf=VDT[12] and vf=VDT[13].
- Per-phase actions (registered on VCLK edge):
  - Phase 1: VAD <= {row, col}.
  - Phase 4: latch decoded attributes into pending regs. CAD <= {chr, vf ? ~POSV[2:0] : POSV[2:0]}.
  - Phase 7: display word <= CDT; display attributes <= pending regs.
  - Every phase i: PIX <= nibble n(i') of display word, where i' = hf ? 7-i : i. Nibble order n(0..7) = [7:4],[3:0],[15:12],[11:8],[23:20],[19:16],[31:28],[27:24].
  - PAL and PRIO update with the display word and are held for 8 pixels.
- OPQ is combinational from the registered PIX and LEN.

## Timing
- VRAM data is valid by the phase-4 edge; char ROM data (read on ~VCLK) is valid by the phase-7 edge.
- The tile addressed in group g is output during group g+1. Pixel i appears on PIX the cycle after the phase-i edge. HOFS absorbs this one-tile latency.
- Reset values: VAD=0, CAD=0, PIX=0, PAL=0, PRIO=0, OPQ=0, SCXL=SCYL=0, all pending and display regs 0.
- Reset mid-line: outputs stay transparent until the first phase-7 load after release. Scroll stays 0 until the next HLATCH.
- A scroll change causes a phase discontinuity at HLATCH only. A partial tile at the line start is permitted and expected.
- If the phase sequence skips (scroll jump), the last loaded word is held until the next phase-7.

## Test plan
- Mode 0, SCX=SCY=0, VDT=16'hC312, CDT=32'h87654321 → CAD={10'h312,row}. Across one group, PIX sequence = 2,1,4,3,6,5,8,7; PAL=3, PRIO=0.
- Mode 2, VDT bit12=1, same CDT → PIX = 7,8,5,6,3,4,1,2. With bit13=1 at POSV[2:0]=2, CAD row = 5.
- Mode 1, VDT=16'h3AFF → chr=10'h1FF, PAL=10, PRIO=1. Pixel 0 → OPQ=0; LEN=0 → OPQ=0 for all pixels.
- Change SCX from 0 to 8'h05 at PH=100 → no effect on the current line. Next line from HLATCH: POSH increases by 5 and VAD column shifts accordingly. Col 31 → 0 wrap is verified.
- Assert RESET for 2 cycles mid-group → all outputs 0 and OPQ=0 until the next phase-7 load, then normal output resumes.

Source files
------------

// File: rtl/tile_layer_gen.sv
// Tilemap scanline generator: scroll-latched tile walk, VRAM attribute fetch,
// 4bpp char ROM fetch, one pixel per VCLK with palette/priority/opacity.
// Latency: tile addressed in 8-pixel group g is shown in group g+1; PIX is
// registered one VCLK after its phase edge. No backpressure; free-running.
// Ports: VCLK/RESET clock and sync reset; PH/PV CRTC counters; SCX/SCY scroll;
// LEN layer enable; VAD/VDT VRAM address/data; CAD/CDT char ROM address/data;
// PIX/PAL/PRIO/OPQ pixel outputs to the colour mixer.
module tile_layer_gen #(
  parameter int COLS_LOG2 = 5,
  parameter int ROWS_LOG2 = 5,
  parameter int HOFS      = 2,
  parameter int VOFS      = 32,
  parameter int HLATCH    = 256,
  parameter int ATTR_MODE = 0
) (
  input  logic                           VCLK,
  input  logic                           RESET,
  input  logic [8:0]                     PH,
  input  logic [8:0]                     PV,
  input  logic [7:0]                     SCX,
  input  logic [7:0]                     SCY,
  input  logic                           LEN,
  output logic [COLS_LOG2+ROWS_LOG2-1:0] VAD,
  input  logic [15:0]                    VDT,
  output logic [12:0]                    CAD,
  input  logic [31:0]                    CDT,
  output logic [3:0]                     PIX,
  output logic [3:0]                     PAL,
  output logic                           PRIO,
  output logic                           OPQ
);

  // scroll registers, sampled once per line in hblank
  logic [7:0] scxl;
  logic [7:0] scyl;

  // scrolled map position, mod 512
  logic [8:0] posh;
  logic [8:0] posv;
  logic [2:0] phase;
  logic [COLS_LOG2-1:0] col;
  logic [ROWS_LOG2-1:0] row;

  assign posh  = PH + {1'b0, scxl} + 9'(HOFS);
  assign posv  = PV + {1'b0, scyl} + 9'(VOFS);
  assign phase = posh[2:0];
  assign col   = posh[COLS_LOG2+2:3];
  assign row   = posv[ROWS_LOG2+2:3];

  // which high position bits go unused depends on the map size
  logic unused_pos;
  assign unused_pos = ^{posh, posv};

  // attribute decode
  logic [9:0] dec_chr;
  logic [3:0] dec_pal;
  logic       dec_prio;
  logic       dec_hf;
  logic       dec_vf;

  always_comb begin
    dec_chr  = {VDT[15:14], VDT[7:0]};
    dec_pal  = VDT[11:8];
    dec_prio = 1'b0;
    dec_hf   = 1'b0;
    dec_vf   = 1'b0;
    case (ATTR_MODE)
      1: begin
        dec_chr  = {1'b0, VDT[13], VDT[7:0]};
        dec_prio = VDT[12];
      end
      2: begin
        dec_hf = VDT[12];
        dec_vf = VDT[13];
      end
      default: begin
      end
    endcase
  end

  // pending attributes (fetched at phase 4) and display state (loaded at phase 7)
  logic [3:0]  pend_pal;
  logic        pend_prio;
  logic        pend_hf;
  logic [31:0] disp_word;
  logic        disp_hf;

  // nibble for this phase; a 3-bit ~phase is 7-phase for the H flip.
  // Within each byte the high nibble is shown first.
  logic [2:0] nib_idx;
  logic [4:0] nib_lsb;

  assign nib_idx = disp_hf ? ~phase : phase;
  assign nib_lsb = {nib_idx[2:1], ~nib_idx[0], 2'b00};

  always_ff @(posedge VCLK) begin
    if (RESET) begin
      scxl      <= '0;
      scyl      <= '0;
      VAD       <= '0;
      CAD       <= '0;
      pend_pal  <= '0;
      pend_prio <= 1'b0;
      pend_hf   <= 1'b0;
      disp_word <= '0;
      disp_hf   <= 1'b0;
      PAL       <= '0;
      PRIO      <= 1'b0;
      PIX       <= '0;
    end else begin
      if (PH == 9'(HLATCH)) begin
        scxl <= SCX;
        scyl <= SCY;
      end
      if (phase == 3'd1) begin
        VAD <= {row, col};
      end
      if (phase == 3'd4) begin
        pend_pal  <= dec_pal;
        pend_prio <= dec_prio;
        pend_hf   <= dec_hf;
        CAD       <= {dec_chr, dec_vf ? ~posv[2:0] : posv[2:0]};
      end
      // a skipped phase 7 (scroll jump) simply holds the previous word
      if (phase == 3'd7) begin
        disp_word <= CDT;
        disp_hf   <= pend_hf;
        PAL       <= pend_pal;
        PRIO      <= pend_prio;
      end
      PIX <= disp_word[nib_lsb +: 4];
    end
  end

  assign OPQ = LEN & (PIX != 4'd0);

endmodule

// File: tb/tb_tile_layer_gen.sv
// Directed bench for tile_layer_gen: three instances (BG, FG, EXT attribute
// layouts) share CRTC counters, scroll, enable and char ROM data; each test
// task drives PH/PV explicitly and compares against hand-computed values.
module tb_tile_layer_gen;

  logic        VCLK = 1'b0;
  logic        RESET;
  logic [8:0]  PH;
  logic [8:0]  PV;
  logic [7:0]  SCX;
  logic [7:0]  SCY;
  logic        LEN;
  logic [31:0] CDT;

  logic [15:0] vdt0, vdt1, vdt2;
  logic [9:0]  vad0, vad1, vad2;
  logic [12:0] cad0, cad1, cad2;
  logic [3:0]  pix0, pix1, pix2;
  logic [3:0]  pal0, pal1, pal2;
  logic        prio0, prio1, prio2;
  logic        opq0, opq1, opq2;

  int checks = 0;
  int errors = 0;

  // expected PIX by phase for CDT=87654321 (forward / H-flipped)
  // and for CDT=87654310 (forward)
  logic [3:0] seq_fwd [0:7] = '{4'd2, 4'd1, 4'd4, 4'd3, 4'd6, 4'd5, 4'd8, 4'd7};
  logic [3:0] seq_rev [0:7] = '{4'd7, 4'd8, 4'd5, 4'd6, 4'd3, 4'd4, 4'd1, 4'd2};
  logic [3:0] seq_z   [0:7] = '{4'd1, 4'd0, 4'd4, 4'd3, 4'd6, 4'd5, 4'd8, 4'd7};

  always #5 VCLK = ~VCLK;

  tile_layer_gen #(.ATTR_MODE(0)) u0 (
    .VCLK(VCLK), .RESET(RESET), .PH(PH), .PV(PV), .SCX(SCX), .SCY(SCY), .LEN(LEN),
    .VAD(vad0), .VDT(vdt0), .CAD(cad0), .CDT(CDT),
    .PIX(pix0), .PAL(pal0), .PRIO(prio0), .OPQ(opq0)
  );

  tile_layer_gen #(.ATTR_MODE(1)) u1 (
    .VCLK(VCLK), .RESET(RESET), .PH(PH), .PV(PV), .SCX(SCX), .SCY(SCY), .LEN(LEN),
    .VAD(vad1), .VDT(vdt1), .CAD(cad1), .CDT(CDT),
    .PIX(pix1), .PAL(pal1), .PRIO(prio1), .OPQ(opq1)
  );

  tile_layer_gen #(.ATTR_MODE(2)) u2 (
    .VCLK(VCLK), .RESET(RESET), .PH(PH), .PV(PV), .SCX(SCX), .SCY(SCY), .LEN(LEN),
    .VAD(vad2), .VDT(vdt2), .CAD(cad2), .CDT(CDT),
    .PIX(pix2), .PAL(pal2), .PRIO(prio2), .OPQ(opq2)
  );

  // apply counters, clock once, settle past the edge
  task automatic tick(input int ph, input int pv);
    PH = 9'(ph);
    PV = 9'(pv);
    @(posedge VCLK);
    #1;
  endtask

  task automatic test_reset;
    RESET = 1'b1;
    for (int i = 0; i < 3; i++) tick(0, 0);
    checks++; if (pix0 !== 4'd0)   begin errors++; $display("FAIL reset_pix got %0h want 0", pix0); end
    checks++; if (pal0 !== 4'd0)   begin errors++; $display("FAIL reset_pal got %0h want 0", pal0); end
    checks++; if (prio0 !== 1'b0)  begin errors++; $display("FAIL reset_prio got %0h want 0", prio0); end
    checks++; if (opq0 !== 1'b0)   begin errors++; $display("FAIL reset_opq got %0h want 0", opq0); end
    checks++; if (vad0 !== 10'd0)  begin errors++; $display("FAIL reset_vad got %0h want 0", vad0); end
    checks++; if (cad0 !== 13'd0)  begin errors++; $display("FAIL reset_cad got %0h want 0", cad0); end
    checks++; if (cad1 !== 13'd0)  begin errors++; $display("FAIL reset_cad1 got %0h want 0", cad1); end
    checks++; if (pix2 !== 4'd0)   begin errors++; $display("FAIL reset_pix2 got %0h want 0", pix2); end
    RESET = 1'b0;
  endtask

  // BG layout, no scroll: posh = PH+2, row = (0+32)>>3 = 4
  task automatic test_mode0;
    vdt0 = 16'hC312;
    CDT  = 32'h87654321;
    for (int ph = 0; ph < 16; ph++) tick(ph, 0);
    for (int ph = 16; ph < 24; ph++) begin
      tick(ph, 0);
      checks++; if (pix0 !== seq_fwd[(ph + 2) % 8]) begin errors++; $display("FAIL m0_pix ph=%0d got %0h want %0h", ph, pix0, seq_fwd[(ph + 2) % 8]); end
      checks++; if (pal0 !== 4'd3)  begin errors++; $display("FAIL m0_pal ph=%0d got %0h want 3", ph, pal0); end
      checks++; if (prio0 !== 1'b0) begin errors++; $display("FAIL m0_prio ph=%0d got %0h want 0", ph, prio0); end
      checks++; if (opq0 !== 1'b1)  begin errors++; $display("FAIL m0_opq ph=%0d got %0h want 1", ph, opq0); end
    end
    // last phase-1 edge at PH=23: posh=25 -> col 3
    checks++; if (vad0 !== 10'd131)   begin errors++; $display("FAIL m0_vad got %0d want 131", vad0); end
    checks++; if (cad0 !== 13'h1890)  begin errors++; $display("FAIL m0_cad got %0h want 1890", cad0); end
  endtask

  task automatic test_hflip;
    vdt2 = 16'h1312;
    for (int ph = 32; ph < 48; ph++) tick(ph, 0);
    for (int ph = 48; ph < 56; ph++) begin
      tick(ph, 0);
      checks++; if (pix2 !== seq_rev[(ph + 2) % 8]) begin errors++; $display("FAIL hf_pix ph=%0d got %0h want %0h", ph, pix2, seq_rev[(ph + 2) % 8]); end
      checks++; if (pal2 !== 4'd3) begin errors++; $display("FAIL hf_pal ph=%0d got %0h want 3", ph, pal2); end
    end
  endtask

  // PV=2: posv = 34, fine row 2; V flip selects row 5
  task automatic test_vflip;
    vdt2 = 16'h2312;
    for (int ph = 56; ph < 64; ph++) tick(ph, 2);
    checks++; if (cad2 !== 13'h0095) begin errors++; $display("FAIL vf_cad got %0h want 0095", cad2); end
    checks++; if (cad0 !== 13'h1892) begin errors++; $display("FAIL vf_cad_noflip got %0h want 1892", cad0); end
  endtask

  task automatic test_fg;
    vdt1 = 16'h3AFF;
    CDT  = 32'h87654310;
    LEN  = 1'b1;
    for (int ph = 64; ph < 80; ph++) tick(ph, 0);
    for (int ph = 80; ph < 88; ph++) begin
      tick(ph, 0);
      checks++; if (pix1 !== seq_z[(ph + 2) % 8]) begin errors++; $display("FAIL fg_pix ph=%0d got %0h want %0h", ph, pix1, seq_z[(ph + 2) % 8]); end
      checks++; if (opq1 !== (seq_z[(ph + 2) % 8] != 4'd0)) begin errors++; $display("FAIL fg_opq ph=%0d got %0h want %0h", ph, opq1, (seq_z[(ph + 2) % 8] != 4'd0)); end
      checks++; if (pal1 !== 4'd10) begin errors++; $display("FAIL fg_pal ph=%0d got %0d want 10", ph, pal1); end
    end
    checks++; if (prio1 !== 1'b1)    begin errors++; $display("FAIL fg_prio got %0h want 1", prio1); end
    checks++; if (cad1 !== 13'h0FF8) begin errors++; $display("FAIL fg_cad got %0h want 0ff8", cad1); end
    LEN = 1'b0;
    for (int ph = 88; ph < 96; ph++) begin
      tick(ph, 0);
      checks++; if (opq1 !== 1'b0) begin errors++; $display("FAIL fg_len_opq ph=%0d got %0h want 0", ph, opq1); end
      checks++; if (pix1 !== seq_z[(ph + 2) % 8]) begin errors++; $display("FAIL fg_len_pix ph=%0d got %0h want %0h", ph, pix1, seq_z[(ph + 2) % 8]); end
    end
    LEN = 1'b1;
    CDT = 32'h87654321;
  endtask

  task automatic test_scroll;
    for (int ph = 96; ph < 260; ph++) begin
      if (ph == 100) SCX = 8'h05;
      tick(ph, 0);
      // same line: still posh = PH+2
      if (ph == 103) begin
        checks++; if (vad0 !== 10'd141) begin errors++; $display("FAIL sc_same_line103 got %0d want 141", vad0); end
      end
      if (ph == 111) begin
        checks++; if (vad0 !== 10'd142) begin errors++; $display("FAIL sc_same_line111 got %0d want 142", vad0); end
      end
    end
    // next line: posh = PH+7, row (1+32)>>3 = 4
    for (int ph = 0; ph <= 250; ph++) begin
      tick(ph, 1);
      if (ph == 10) begin
        checks++; if (vad0 !== 10'd130) begin errors++; $display("FAIL sc_next_line got %0d want 130", vad0); end
      end
      if (ph == 242) begin
        checks++; if (vad0 !== 10'd159) begin errors++; $display("FAIL sc_col31 got %0d want 159", vad0); end
      end
      if (ph == 250) begin
        checks++; if (vad0 !== 10'd128) begin errors++; $display("FAIL sc_col_wrap got %0d want 128", vad0); end
      end
    end
  endtask

  task automatic test_reset_mid;
    vdt0 = 16'hC312;
    CDT  = 32'h87654321;
    for (int ph = 0; ph < 20; ph++) tick(ph, 0);
    RESET = 1'b1;
    tick(20, 0);
    tick(21, 0);
    checks++; if (pix0 !== 4'd0)  begin errors++; $display("FAIL rm_pix got %0h want 0", pix0); end
    checks++; if (pal0 !== 4'd0)  begin errors++; $display("FAIL rm_pal got %0h want 0", pal0); end
    checks++; if (opq0 !== 1'b0)  begin errors++; $display("FAIL rm_opq got %0h want 0", opq0); end
    checks++; if (vad0 !== 10'd0) begin errors++; $display("FAIL rm_vad got %0h want 0", vad0); end
    checks++; if (cad0 !== 13'd0) begin errors++; $display("FAIL rm_cad got %0h want 0", cad0); end
    RESET = 1'b0;
    // scroll back to 0: posh = PH+2, phase-7 load at PH=29
    for (int ph = 22; ph < 29; ph++) begin
      tick(ph, 0);
      checks++; if (pix0 !== 4'd0) begin errors++; $display("FAIL rm_hold_pix ph=%0d got %0h want 0", ph, pix0); end
      checks++; if (pal0 !== 4'd0) begin errors++; $display("FAIL rm_hold_pal ph=%0d got %0h want 0", ph, pal0); end
      checks++; if (opq0 !== 1'b0) begin errors++; $display("FAIL rm_hold_opq ph=%0d got %0h want 0", ph, opq0); end
    end
    tick(29, 0);
    checks++; if (pal0 !== 4'd3) begin errors++; $display("FAIL rm_load_pal got %0h want 3", pal0); end
    for (int ph = 30; ph < 34; ph++) begin
      tick(ph, 0);
      checks++; if (pix0 !== seq_fwd[(ph + 2) % 8]) begin errors++; $display("FAIL rm_resume_pix ph=%0d got %0h want %0h", ph, pix0, seq_fwd[(ph + 2) % 8]); end
    end
  endtask

  initial begin
    RESET = 1'b1;
    PH    = '0;
    PV    = '0;
    SCX   = '0;
    SCY   = '0;
    LEN   = 1'b1;
    CDT   = '0;
    vdt0  = '0;
    vdt1  = '0;
    vdt2  = '0;
    test_reset;
    test_mode0;
    test_hflip;
    test_vflip;
    test_fg;
    test_scroll;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
